// File: rtl/fb_scanout.sv
// fb_scanout: scales a double-buffered 256x192 4-bit framebuffer to 1024x768,
// maps indices through a writable 16-entry palette and delays the timing
// signals so they line up with the colour output.
module fb_scanout #(
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W_BITS   = 8,
  parameter int FB_WORDS    = 49152,
  parameter int ADDR_W      = 17,
  parameter int FB_LATENCY  = 2
) (
  input  logic              vclock,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [3:0]        fb_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_addr,
  input  logic [11:0]       pal_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              buf_sel,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic              frame_start,
  output logic [11:0]       rgb
);

  // Address register + BRAM read latency + palette output register.
  localparam int L = FB_LATENCY + 2;
  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FB_WORDS);

  // Timing shift registers; bit 0 is the newest sample, bit L-1 is the output.
  logic [L-1:0] hs_pipe_q, hs_pipe_d;
  logic [L-1:0] vs_pipe_q, vs_pipe_d;
  logic [L-1:0] bl_pipe_q, bl_pipe_d;
  logic [L-1:0] fs_pipe_q, fs_pipe_d;

  logic [ADDR_W-1:0]    fb_addr_q, fb_addr_d;
  logic [FB_W_BITS-1:0] src_x;
  logic [ADDR_W-1:0]    src_y;
  logic [ADDR_W-1:0]    buf_base;

  logic [11:0] rgb_q, rgb_d;
  logic [11:0] pal_q [16];
  logic [11:0] pal_d [16];

  logic vsync_prev_q, vsync_prev_d;
  logic pending_q, pending_d;
  logic buf_sel_q, buf_sel_d;
  logic swap_ack_q, swap_ack_d;
  logic vs_fall;

  // Shift the sync, blank and frame-start flags one stage per clock.
  always_comb begin
    hs_pipe_d = {hs_pipe_q[L-2:0], hsync_in};
    vs_pipe_d = {vs_pipe_q[L-2:0], vsync_in};
    bl_pipe_d = {bl_pipe_q[L-2:0], blank_in};
    fs_pipe_d = {fs_pipe_q[L-2:0], (hcount == '0) && (vcount == '0)};
  end

  // Source-pixel address from the scaled screen position; held during blanking.
  always_comb begin
    src_x     = hcount[SCALE_SHIFT +: FB_W_BITS];
    src_y     = ADDR_W'(vcount >> SCALE_SHIFT);
    buf_base  = buf_sel_q ? BUF1_BASE : '0;
    fb_addr_d = fb_addr_q;
    if (!blank_in) begin
      fb_addr_d = buf_base + (src_y << FB_W_BITS) + ADDR_W'(src_x);
    end
  end

  // Palette lookup on the returned index; blanked pixels are forced to black.
  always_comb begin
    rgb_d = bl_pipe_q[L-2] ? 12'h000 : pal_q[fb_data];
  end

  // Palette write port; a same-cycle read sees the value before the write.
  always_comb begin
    pal_d = pal_q;
    if (pal_we) begin
      pal_d[pal_addr] = pal_data;
    end
  end

  // Requests collapse into one pending swap, applied only on the vsync falling edge.
  always_comb begin
    vs_fall      = vsync_prev_q && !vsync_in;
    vsync_prev_d = vsync_in;
    buf_sel_d    = buf_sel_q;
    pending_d    = pending_q || swap_req;
    swap_ack_d   = 1'b0;
    if (vs_fall && (pending_q || swap_req)) begin
      buf_sel_d  = !buf_sel_q;
      swap_ack_d = 1'b1;
      pending_d  = 1'b0;
    end
  end

  // Pipeline, address and swap-control registers.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      bl_pipe_q    <= '1;
      fs_pipe_q    <= '0;
      fb_addr_q    <= '0;
      rgb_q        <= '0;
      vsync_prev_q <= 1'b1;
      pending_q    <= 1'b0;
      buf_sel_q    <= 1'b0;
      swap_ack_q   <= 1'b0;
    end else begin
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      bl_pipe_q    <= bl_pipe_d;
      fs_pipe_q    <= fs_pipe_d;
      fb_addr_q    <= fb_addr_d;
      rgb_q        <= rgb_d;
      vsync_prev_q <= vsync_prev_d;
      pending_q    <= pending_d;
      buf_sel_q    <= buf_sel_d;
      swap_ack_q   <= swap_ack_d;
    end
  end

  // Palette register file, reset to a greyscale ramp.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= {3{4'(i)}};
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign rgb         = rgb_q;
  assign hsync_out   = hs_pipe_q[L-1];
  assign vsync_out   = vs_pipe_q[L-1];
  assign blank_out   = bl_pipe_q[L-1];
  assign frame_start = fs_pipe_q[L-1];
  assign buf_sel     = buf_sel_q;
  assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout: drives 1024x768 timing segments with random
// palette traffic, predicts every output with a behavioural model feeding a
// scoreboard queue, and adds position-keyed probes for the boundary cases.
module tb_fb_scanout;

  localparam int SCALE_SHIFT = 2;
  localparam int FB_W_BITS   = 8;
  localparam int FB_WORDS    = 49152;
  localparam int ADDR_W      = 17;
  localparam int FB_LATENCY  = 2;
  localparam int L           = FB_LATENCY + 2;

  logic              vclock = 1'b0;
  logic              reset  = 1'b1;
  logic [10:0]       hcount = 11'd1100;
  logic [9:0]        vcount = 10'd800;
  logic              hsync_in = 1'b1;
  logic              vsync_in = 1'b1;
  logic              blank_in = 1'b1;
  logic [ADDR_W-1:0] fb_addr;
  logic [3:0]        fb_data;
  logic              pal_we = 1'b0;
  logic [3:0]        pal_addr = 4'd0;
  logic [11:0]       pal_data = 12'd0;
  logic              swap_req = 1'b0;
  logic              swap_ack;
  logic              buf_sel;
  logic              hsync_out;
  logic              vsync_out;
  logic              blank_out;
  logic              frame_start;
  logic [11:0]       rgb;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int pass_id    = 0;

  always #5 vclock = ~vclock;

  fb_scanout #(
    .SCALE_SHIFT(SCALE_SHIFT),
    .FB_W_BITS  (FB_W_BITS),
    .FB_WORDS   (FB_WORDS),
    .ADDR_W     (ADDR_W),
    .FB_LATENCY (FB_LATENCY)
  ) dut (
    .vclock     (vclock),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blank_in   (blank_in),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .buf_sel    (buf_sel),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out),
    .frame_start(frame_start),
    .rgb        (rgb)
  );

  // BRAM model: the stored word is simply the low nibble of its address.
  logic [3:0] bram_pipe [FB_LATENCY] = '{default: 4'd0};
  always @(posedge vclock) begin
    bram_pipe[0] <= fb_addr[3:0];
    for (int i = 1; i < FB_LATENCY; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign fb_data = bram_pipe[FB_LATENCY-1];

  always @(posedge vclock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic hs; logic vs; logic bl; logic fs; logic [3:0] idx;
  } ent_t;
  typedef struct packed {
    logic hs; logic vs; logic bl; logic fs; logic [11:0] rgb;
    logic [ADDR_W-1:0] addr; logic ack; logic bs;
  } exp_t;

  ent_t        inflight [$];
  exp_t        exp_q [$];
  logic [11:0] pal_m [16];
  int          m_addr   = 0;
  logic        m_buf    = 1'b0;
  logic        m_pend   = 1'b0;
  logic        m_vsprev = 1'b1;

  always @(posedge vclock or posedge reset) begin
    ent_t ent;
    ent_t old;
    exp_t e;
    logic ack;
    if (reset) begin
      inflight.delete();
      for (int i = 0; i < L - 1; i++) inflight.push_back('{hs: 1'b1, vs: 1'b1, bl: 1'b1, fs: 1'b0, idx: 4'd0});
      for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
      m_addr = 0; m_buf = 1'b0; m_pend = 1'b0; m_vsprev = 1'b1;
      exp_q.delete();
    end else begin
      ack = 1'b0;
      if (!blank_in)
        m_addr = (m_buf ? FB_WORDS : 0)
               + (int'(vcount) / (1 << SCALE_SHIFT)) * (1 << FB_W_BITS)
               + (int'(hcount) / (1 << SCALE_SHIFT)) % (1 << FB_W_BITS);
      ent = '{hs: hsync_in, vs: vsync_in, bl: blank_in,
              fs: (hcount == 11'd0 && vcount == 10'd0), idx: 4'(m_addr % 16)};
      inflight.push_back(ent);
      old = inflight.pop_front();
      e.hs  = old.hs;
      e.vs  = old.vs;
      e.bl  = old.bl;
      e.fs  = old.fs;
      e.rgb = old.bl ? 12'h000 : pal_m[old.idx];
      if (pal_we) pal_m[pal_addr] = pal_data;
      if (m_vsprev && !vsync_in && (m_pend || swap_req)) begin
        m_buf = !m_buf; ack = 1'b1; m_pend = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
      m_vsprev = vsync_in;
      e.addr = ADDR_W'(m_addr);
      e.ack  = ack;
      e.bs   = m_buf;
      exp_q.push_back(e);
    end
  end

  // ---------------- position-keyed probes ----------------
  typedef struct { int pass; int vc; int hc; string name; int kind; int exp; } plan_t;
  typedef struct { int due; string name; int kind; int exp; } probe_t;
  plan_t  plan [$];
  probe_t probes [$];

  // kind: 0 fb_addr, 1 rgb, 2 frame_start, 3 swap_ack, 4 buf_sel
  task automatic addPlan(input int pass, input int vc, input int hc, input string name, input int kind, input int exp);
    plan.push_back('{pass, vc, hc, name, kind, exp});
  endtask

  task automatic scheduleProbes(input int vc, input int hc);
    for (int i = plan.size() - 1; i >= 0; i--) begin
      if (plan[i].pass == pass_id && plan[i].vc == vc && plan[i].hc == hc) begin
        probes.push_back('{cyc + 1 + ((plan[i].kind == 1 || plan[i].kind == 2) ? L - 1 : 0),
                           plan[i].name, plan[i].kind, plan[i].exp});
        plan.delete(i);
      end
    end
  endtask

  // ---------------- monitor: scoreboard and probes ----------------
  always @(negedge vclock) begin
    exp_t e;
    int act;
    if (!reset) begin
      for (int i = probes.size() - 1; i >= 0; i--) begin
        if (probes[i].due == cyc) begin
          case (probes[i].kind)
            0:       act = int'(fb_addr);
            1:       act = int'(rgb);
            2:       act = int'(frame_start);
            3:       act = int'(swap_ack);
            default: act = int'(buf_sel);
          endcase
          checkOutput(probes[i].name, act, probes[i].exp);
          probes.delete(i);
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_hsync_out",   int'(hsync_out),   int'(e.hs));
        checkOutput("sb_vsync_out",   int'(vsync_out),   int'(e.vs));
        checkOutput("sb_blank_out",   int'(blank_out),   int'(e.bl));
        checkOutput("sb_frame_start", int'(frame_start), int'(e.fs));
        checkOutput("sb_rgb",         int'(rgb),         int'(e.rgb));
        checkOutput("sb_fb_addr",     int'(fb_addr),     int'(e.addr));
        checkOutput("sb_swap_ack",    int'(swap_ack),    int'(e.ack));
        checkOutput("sb_buf_sel",     int'(buf_sel),     int'(e.bs));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input int hc, input int vc, input logic sw,
                               input logic we, input logic [3:0] pa, input logic [11:0] pd);
    hcount   = 11'(hc);
    vcount   = 10'(vc);
    hsync_in = !(hc >= 1048 && hc < 1184);
    vsync_in = !(vc >= 776 && vc < 782);
    blank_in = (hc >= 1024) || (vc >= 768);
    swap_req = sw;
    pal_we   = we;
    pal_addr = pa;
    pal_data = pd;
    @(posedge vclock);
    #1;
  endtask

  // One line segment; entry 5 may be written at pw_hc, otherwise random writes hit entries 7..15.
  task automatic runLine(input int vc, input int h0, input int h1, input int sw_a, input int sw_b,
                         input int pw_hc, input logic [11:0] pw_data);
    for (int hc = h0; hc <= h1; hc++) begin
      logic sw;
      logic we;
      logic [3:0] pa;
      logic [11:0] pd;
      sw = (hc == sw_a) || (hc == sw_b);
      we = 1'b0; pa = 4'd0; pd = 12'd0;
      if (hc == pw_hc) begin
        we = 1'b1; pa = 4'd5; pd = pw_data;
      end else if ($urandom_range(0, 15) == 0) begin
        we = 1'b1; pa = 4'($urandom_range(7, 15)); pd = 12'($urandom);
      end
      scheduleProbes(vc, hc);
      applyStimulus(hc, vc, sw, we, pa, pd);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_hsync_out"},   int'(hsync_out),   1);
    checkOutput({tag, "_vsync_out"},   int'(vsync_out),   1);
    checkOutput({tag, "_blank_out"},   int'(blank_out),   1);
    checkOutput({tag, "_rgb"},         int'(rgb),         0);
    checkOutput({tag, "_fb_addr"},     int'(fb_addr),     0);
    checkOutput({tag, "_buf_sel"},     int'(buf_sel),     0);
    checkOutput({tag, "_swap_ack"},    int'(swap_ack),    0);
    checkOutput({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  initial begin
    repeat (3) @(posedge vclock);
    #1;
    checkResetValues("por");
    reset = 1'b0;

    // Palette entry 5 written during vertical blank.
    pass_id = 1;
    runLine(800, 0, 10, -1, -1, 2, 12'hF0A);

    // Line 0: frame start, first pixel, addressing, palette lookups.
    pass_id = 2;
    addPlan(2, 0, 0, "fs_pixel00", 2, 1);
    addPlan(2, 0, 0, "rgb_pixel00", 1, 12'h000);
    addPlan(2, 0, 1, "fs_single", 2, 0);
    for (int h = 4; h <= 7; h++) addPlan(2, 0, h, "addr_x1", 0, 1);
    addPlan(2, 0, 20, "rgb_pal5", 1, 12'hF0A);
    addPlan(2, 0, 24, "rgb_pal6_grey", 1, 12'h666);
    addPlan(2, 0, 1100, "addr_hold_blank", 0, 255);
    addPlan(2, 0, 1343, "addr_hold_eol", 0, 255);
    runLine(0, 0, 1343, -1, -1, -1, 12'h000);

    // Line 1: two swap requests, and a palette write landing on the edge that reads entry 5.
    pass_id = 3;
    addPlan(3, 1, 20, "rgb_pal5_old_on_write", 1, 12'hF0A);
    addPlan(3, 1, 21, "rgb_pal5_new", 1, 12'h123);
    runLine(1, 0, 1343, 100, 500, 23, 12'h123);

    // Last visible pixel in buffer 0, then the vsync edge applies the swap once.
    pass_id = 4;
    addPlan(4, 767, 1023, "addr_last_buf0", 0, 49151);
    addPlan(4, 776, 0, "ack_at_edge", 3, 1);
    addPlan(4, 776, 0, "bufsel_swapped", 4, 1);
    addPlan(4, 776, 1, "ack_single_pulse", 3, 0);
    addPlan(4, 776, 2, "ack_late_req_deferred", 3, 0);
    addPlan(4, 776, 2, "bufsel_held", 4, 1);
    runLine(767, 1000, 1343, -1, -1, -1, 12'h000);
    runLine(775, 1330, 1343, -1, -1, -1, 12'h000);
    runLine(776, 0, 40, 1, -1, -1, 12'h000);

    // Buffer 1 addressing, then the deferred swap at the next frame's edge.
    pass_id = 5;
    addPlan(5, 767, 1023, "addr_last_buf1", 0, 98303);
    addPlan(5, 776, 0, "ack_deferred_swap", 3, 1);
    addPlan(5, 776, 0, "bufsel_back_to_0", 4, 0);
    runLine(767, 1018, 1030, -1, -1, -1, 12'h000);
    runLine(775, 1335, 1343, -1, -1, -1, 12'h000);
    runLine(776, 0, 20, -1, -1, -1, 12'h000);

    // Move to buffer 1 so the reset clearing buf_sel is observable.
    pass_id = 6;
    addPlan(6, 776, 0, "bufsel_before_reset", 4, 1);
    runLine(300, 0, 10, 3, -1, -1, 12'h000);
    runLine(775, 1335, 1343, -1, -1, -1, 12'h000);
    runLine(776, 0, 5, -1, -1, -1, 12'h000);

    // Mid-frame reset with a swap pending.
    pass_id = 7;
    runLine(300, 480, 499, 490, -1, -1, 12'h000);
    hcount = 11'd500;
    vcount = 10'd300;
    #2;
    reset = 1'b1;
    #1;
    probes.delete();
    checkResetValues("midrst");
    repeat (2) @(posedge vclock);
    #1;
    reset = 1'b0;

    // Pending swap was lost; first frame restarts cleanly from buffer 0.
    pass_id = 8;
    addPlan(8, 776, 0, "ack_pending_lost", 3, 0);
    addPlan(8, 776, 0, "bufsel_after_reset", 4, 0);
    addPlan(8, 0, 0, "fs_after_reset", 2, 1);
    addPlan(8, 0, 0, "rgb_pixel00_after_reset", 1, 12'h000);
    addPlan(8, 0, 20, "rgb_pal5_reset_grey", 1, 12'h555);
    runLine(775, 1335, 1343, -1, -1, -1, 12'h000);
    runLine(776, 0, 5, -1, -1, -1, 12'h000);
    runLine(0, 0, 30, -1, -1, -1, 12'h000);
    runLine(800, 0, 10, -1, -1, -1, 12'h000);

    checkOutput("plan_all_reached", plan.size(), 0);
    checkOutput("probes_all_checked", probes.size(), 0);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Downstream consumer of the xvga timing generator (1024x768 @ 60 Hz).
- Reads a double-buffered, 4-bit-indexed, 256x192 framebuffer from external BRAM, scaling each source pixel to a 4x4 screen block. Maps indices through a writable 16-entry palette.
- Outputs 12-bit RGB with hsync/vsync/blank delayed to match the pipeline.
- Performs tear-free front/back buffer swaps, requested by the draw engine and applied at vsync.

Parameters:
- SCALE_SHIFT, 2, log2 of the screen-pixels-per-source-pixel factor, applied to both axes.
- FB_W_BITS, 8, log2 of the source line width (256 words per line).
- FB_WORDS, 49152, words per buffer (256x192).
- ADDR_W, 17, fb_addr width; must be able to hold 2*FB_WORDS-1.
- FB_LATENCY, 2, BRAM read latency in cycles, from fb_addr to valid fb_data; legal range 1..3.

Ports:
- vclock  in  1  pixel clock (65 MHz).
- reset  in  1  asynchronous, active-high.
- hcount  in  11  pixel number from timing generator.
- vcount  in  10  line number from timing generator.
- hsync_in  in  1  active-low, undelayed.
- vsync_in  in  1  active-low, undelayed.
- blank_in  in  1  undelayed blank.
- fb_addr  out  ADDR_W  registered BRAM read address.
- fb_data  in  4  palette index returned FB_LATENCY cycles after fb_addr.
- pal_we  in  1  palette write enable.
- pal_addr  in  4  palette entry index.
- pal_data  in  12  {R[3:0],G[3:0],B[3:0]}.
- swap_req  in  1  single-cycle request pulse from the draw engine.
- swap_ack  out  1  single-cycle pulse when a swap is applied.
- buf_sel  out  1  buffer currently displayed; the draw engine writes ~buf_sel.
- hsync_out  out  1  hsync_in delayed by L.
- vsync_out  out  1  vsync_in delayed by L.
- blank_out  out  1  blank_in delayed by L.
- frame_start  out  1  pulse aligned with output pixel (0,0).
- rgb  out  12  pixel colour.

Behaviour:
- Interface: one clock, vclock; reset is asynchronous, active-high, and clears every register immediately.
- Total latency L = FB_LATENCY + 2 (default 4):
  - 1 cycle for the address register.
  - FB_LATENCY cycles in the BRAM.
  - 1 cycle for the palette output register.
- Inputs sampled at cycle t appear on hsync_out, vsync_out, blank_out and rgb at cycle t+L.
- Address stage:
  - x = hcount >> SCALE_SHIFT (low FB_W_BITS bits).
  - y = vcount >> SCALE_SHIFT.
  - fb_addr <= (buf_sel ? FB_WORDS : 0) + (y << FB_W_BITS) + x.
  - Computed only when blank_in = 0; while blank_in = 1, fb_addr holds its last value.
- A blank flag travels down the pipeline with the data. When the delayed blank is 1, rgb <= 0 regardless of fb_data.
- Palette:
  - 16 x 12-bit register file; reset value of entry i is {i,i,i} (greyscale).
  - A write lands at the clock edge. A read of the same entry in the same cycle returns the old value.
- frame_start: the input condition (hcount==0 && vcount==0) is delayed by L. It is high for exactly one cycle, coincident with rgb for pixel (0,0).
- Swap:
  - swap_req sets a pending flag; any number of pulses before the next swap collapse into one swap.
  - vsync falling edge = vsync_prev==1 && vsync_in==0, detected on the undelayed input; vsync_prev resets to 1.
  - On that edge with pending (or with swap_req in the same cycle): buf_sel toggles, swap_ack pulses 1 cycle, and pending clears.
  - A swap_req arriving in the cycle after the edge stays pending for the next frame.
  - No swap occurs outside the vsync edge.
- buf_sel changes only during vertical blank, so the active region of a frame is always read from a single buffer.
- Reset values:
  - hsync_out = 1, vsync_out = 1, blank_out = 1.
  - rgb = 0, fb_addr = 0, buf_sel = 0.
  - swap_ack = 0, frame_start = 0, pending = 0.
  - All pipeline stages cleared to blank = 1 and syncs = 1.
- Reset mid-frame: outputs show blank/idle sync until L cycles after reset release plus the next valid input. Pending swaps are lost.

Test Plan:
- Latency: drive the xvga-style timing with a BRAM model (FB_LATENCY = 2) returning fb_data = addr[3:0] -> hsync_out/vsync_out/blank_out equal the inputs delayed exactly 4 cycles; first active rgb = palette[0] = 12'h000.
- Addressing: hcount = 1023, vcount = 767, buf_sel = 0 -> fb_addr = 49151. Same position with buf_sel = 1 -> fb_addr = 98303. hcount 4..7 on line 0 all give fb_addr = 1.
- Blanking: hcount 1024..1343 -> fb_addr holds 255 (line 0); rgb = 0 for every cycle blank_out = 1.
- Palette: write entry 5 = 12'hF0A, then display index 5 -> rgb = 12'hF0A. Entry 6 untouched -> 12'h666. Same-cycle write/read of entry 5 returns the old value.
- Swap: two swap_req pulses during the active region -> exactly one swap_ack, at the vsync_in falling edge (line 776), and buf_sel 0 -> 1. swap_req one cycle after the edge -> swap deferred to the next frame's edge.
- Reset: assert reset at hcount = 500, vcount = 300 -> outputs go immediately to the reset values. After release, the first frame_start coincides with rgb of pixel (0,0), with buf_sel = 0.
